// File: rtl/ipv4_hdr_chk_verify.sv
// Receive-side IPv4 header checksum verifier: sums all IHL words of a header
// (checksum field included) and reports ok / bad checksum / bad header once per header.
module ipv4_hdr_chk_verify #(
  parameter int          ACC_W      = 21,
  parameter logic [3:0]  EXPECT_VER = 4'd4,
  parameter logic [3:0]  MIN_IHL    = 4'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [31:0] in_word,
  output logic        in_ready,
  output logic        res_valid,
  output logic        res_ok,
  output logic        res_bad_csum,
  output logic        res_bad_hdr,
  output logic [3:0]  res_ihl,
  output logic [15:0] res_sum,
  output logic        abort
);

  // Handshake: a word transfers on a rising clk edge where in_valid and in_ready are both 1.
  typedef enum logic [2:0] {IDLE, ACCUM, FOLD1, FOLD2, REPORT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [3:0]         ihl_q, ihl_d;
  logic [16:0]        s1_q, s1_d;
  logic               res_ok_q, res_ok_d;
  logic               res_bad_csum_q, res_bad_csum_d;
  logic               res_bad_hdr_q, res_bad_hdr_d;
  logic [3:0]         res_ihl_q, res_ihl_d;
  logic [15:0]        res_sum_q, res_sum_d;
  logic               abort_q, abort_d;

  logic               accept;
  logic               hdr_legal;
  logic [ACC_W-1:0]   word_sum;
  logic [15:0]        fold2_sum;

  assign word_sum  = ACC_W'(in_word[31:16]) + ACC_W'(in_word[15:0]);
  assign hdr_legal = (in_word[31:28] == EXPECT_VER) && (in_word[27:24] >= MIN_IHL);
  assign fold2_sum = s1_q[15:0] + {15'd0, s1_q[16]};

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    wcnt_d         = wcnt_q;
    ihl_d          = ihl_q;
    s1_d           = s1_q;
    res_ok_d       = res_ok_q;
    res_bad_csum_d = res_bad_csum_q;
    res_bad_hdr_d  = res_bad_hdr_q;
    res_ihl_d      = res_ihl_q;
    res_sum_d      = res_sum_q;
    abort_d        = 1'b0;
    in_ready       = (state_q == IDLE) || (state_q == ACCUM);
    accept         = in_valid && in_ready;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept && in_sof) begin
          // A new word 0 always restarts; mid-header it discards the old header.
          abort_d = (state_q == ACCUM);
          ihl_d   = in_word[27:24];
          acc_d   = word_sum;
          wcnt_d  = 4'd1;
          if (hdr_legal) begin
            state_d = ACCUM;
          end else begin
            state_d        = REPORT;
            res_ok_d       = 1'b0;
            res_bad_csum_d = 1'b0;
            res_bad_hdr_d  = 1'b1;
            res_ihl_d      = in_word[27:24];
            res_sum_d      = 16'd0;
          end
        end else if (accept && (state_q == ACCUM)) begin
          acc_d  = acc_q + word_sum;
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_d == ihl_q) state_d = FOLD1;
        end
      end
      FOLD1: begin
        s1_d    = 17'(acc_q[15:0]) + 17'(acc_q[ACC_W-1:16]);
        state_d = FOLD2;
      end
      FOLD2: begin
        // End-around carry; the result register doubles as the held res_sum.
        res_sum_d      = fold2_sum;
        res_ok_d       = (fold2_sum == 16'hFFFF);
        res_bad_csum_d = (fold2_sum != 16'hFFFF);
        res_bad_hdr_d  = 1'b0;
        res_ihl_d      = ihl_q;
        state_d        = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      wcnt_q         <= '0;
      ihl_q          <= '0;
      s1_q           <= '0;
      res_ok_q       <= 1'b0;
      res_bad_csum_q <= 1'b0;
      res_bad_hdr_q  <= 1'b0;
      res_ihl_q      <= '0;
      res_sum_q      <= '0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      wcnt_q         <= wcnt_d;
      ihl_q          <= ihl_d;
      s1_q           <= s1_d;
      res_ok_q       <= res_ok_d;
      res_bad_csum_q <= res_bad_csum_d;
      res_bad_hdr_q  <= res_bad_hdr_d;
      res_ihl_q      <= res_ihl_d;
      res_sum_q      <= res_sum_d;
      abort_q        <= abort_d;
    end
  end

  assign res_valid    = (state_q == REPORT);
  assign res_ok       = res_ok_q;
  assign res_bad_csum = res_bad_csum_q;
  assign res_bad_hdr  = res_bad_hdr_q;
  assign res_ihl      = res_ihl_q;
  assign res_sum      = res_sum_q;
  assign abort        = abort_q;

endmodule
